// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates a CPU instruction-fetch port and a data (load/store) port onto
//   a single memory bus. One transfer is in flight at a time. Simultaneous
//   requests alternate between the ports, so neither port can starve the
//   other. A bus watchdog aborts transfers the memory never acknowledges.
//   All outputs come straight from flops.
//
// Parameters
//   TIMEOUT       cycles to wait for i_mem_ack before aborting (1..255)
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_stb_inst, i_iaddr     fetch request / address (held until o_ack_inst)
//   i_flush_inst            cancel a pending or in-flight fetch
//   o_ack_inst, o_inst      fetch done pulse / fetched instruction
//   i_stb_data, i_daddr     data request / address (held until o_ack_data)
//   i_dwdata, i_dwe, i_dsel store data, write enable, byte lanes
//   o_ack_data, o_drdata    data done pulse / load data
//   o_err                   with an ack: the transfer timed out
//   o_mem_*                 memory bus request side
//   i_mem_ack, i_mem_rdata  memory completion and read data
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transfer; arbitrate and grant at most one request
// BUSY_I | fetch on the bus, waiting for i_mem_ack or the watchdog
// BUSY_D | load/store on the bus, waiting for i_mem_ack or the watchdog
// RESP   | one cycle: owning ack (and o_err) presented, then IDLE
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stb_inst,
  input  logic [31:0] i_iaddr,
  input  logic        i_flush_inst,
  output logic        o_ack_inst,
  output logic [31:0] o_inst,
  input  logic        i_stb_data,
  input  logic [31:0] i_daddr,
  input  logic [31:0] i_dwdata,
  input  logic        i_dwe,
  input  logic [3:0]  i_dsel,
  output logic        o_ack_data,
  output logic [31:0] o_drdata,
  output logic        o_err,
  output logic        o_mem_stb,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_sel,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_data_q, last_data_d;   // 1: data port won the last grant
  logic [7:0]  timer_q, timer_d;
  logic        drop_q, drop_d;

  logic        ack_inst_q, ack_inst_d;
  logic [31:0] inst_q, inst_d;
  logic        ack_data_q, ack_data_d;
  logic [31:0] drdata_q, drdata_d;
  logic        err_q, err_d;
  logic        mem_stb_q, mem_stb_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_sel_q, mem_sel_d;

  // Arbitration and watchdog helpers
  logic        inst_req;
  logic        data_req;
  logic        grant_data;
  logic [7:0]  timer_inc;
  logic        timeout_hit;
  logic        drop_now;

  assign inst_req    = i_stb_inst & ~i_flush_inst;
  assign data_req    = i_stb_data;
  // Data wins when it is alone, or on a tie when the fetch port won last.
  assign grant_data  = data_req & (~inst_req | ~last_data_q);
  assign timer_inc   = timer_q + 8'd1;
  assign timeout_hit = (timer_inc == TIMEOUT_CNT);
  // A flush arriving in the very cycle the fetch completes still drops it.
  assign drop_now    = drop_q | i_flush_inst;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      timer_q     <= 8'd0;
      drop_q      <= 1'b0;
      ack_inst_q  <= 1'b0;
      inst_q      <= 32'd0;
      ack_data_q  <= 1'b0;
      drdata_q    <= 32'd0;
      err_q       <= 1'b0;
      mem_stb_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_sel_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      timer_q     <= timer_d;
      drop_q      <= drop_d;
      ack_inst_q  <= ack_inst_d;
      inst_q      <= inst_d;
      ack_data_q  <= ack_data_d;
      drdata_q    <= drdata_d;
      err_q       <= err_d;
      mem_stb_q   <= mem_stb_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    timer_d     = timer_q;
    drop_d      = drop_q;
    ack_inst_d  = 1'b0;
    inst_d      = inst_q;
    ack_data_d  = 1'b0;
    drdata_d    = drdata_q;
    err_d       = 1'b0;
    mem_stb_d   = mem_stb_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;

    case (state_q)
      IDLE: begin
        timer_d = 8'd0;
        drop_d  = 1'b0;
        if (inst_req || data_req) begin
          mem_stb_d = 1'b1;
          if (grant_data) begin
            state_d     = BUSY_D;
            last_data_d = 1'b1;
            mem_we_d    = i_dwe;
            mem_addr_d  = i_daddr;
            mem_wdata_d = i_dwdata;
            mem_sel_d   = i_dsel;
          end else begin
            state_d     = BUSY_I;
            last_data_d = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_iaddr;
            mem_wdata_d = 32'd0;
            mem_sel_d   = 4'b1111;
          end
        end
      end

      BUSY_I: begin
        drop_d = drop_now;
        if (i_mem_ack) begin
          state_d   = RESP;
          mem_stb_d = 1'b0;
          if (!drop_now) begin
            inst_d     = i_mem_rdata;
            ack_inst_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d   = RESP;
          mem_stb_d = 1'b0;
          timer_d   = timer_inc;
          // A dropped fetch produces no ack, so it cannot flag an error either.
          if (!drop_now) begin
            inst_d     = NOP_INST;
            ack_inst_d = 1'b1;
            err_d      = 1'b1;
          end
        end else begin
          timer_d = timer_inc;
        end
      end

      BUSY_D: begin
        if (i_mem_ack) begin
          state_d    = RESP;
          mem_stb_d  = 1'b0;
          ack_data_d = 1'b1;
          if (!mem_we_q) begin
            drdata_d = i_mem_rdata;
          end
        end else if (timeout_hit) begin
          state_d    = RESP;
          mem_stb_d  = 1'b0;
          timer_d    = timer_inc;
          ack_data_d = 1'b1;
          err_d      = 1'b1;
          if (!mem_we_q) begin
            drdata_d = 32'd0;
          end
        end else begin
          timer_d = timer_inc;
        end
      end

      RESP: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_ack_inst  = ack_inst_q;
  assign o_inst      = inst_q;
  assign o_ack_data  = ack_data_q;
  assign o_drdata    = drdata_q;
  assign o_err       = err_q;
  assign o_mem_stb   = mem_stb_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_sel   = mem_sel_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed and randomized transfers checked
// against a transaction-level model (expected latency, grant order, data).
module tb_mem_arbiter;

  localparam int T = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stb_inst, i_flush_inst, i_stb_data, i_dwe, i_mem_ack;
  logic [31:0] i_iaddr, i_daddr, i_dwdata, i_mem_rdata;
  logic [3:0]  i_dsel;
  logic        o_ack_inst, o_ack_data, o_err, o_mem_stb, o_mem_we;
  logic [31:0] o_inst, o_drdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_sel;

  int vectors = 0;
  int miscompares = 0;
  int mem_wait = 0;

  // Transaction-level model state
  bit          last_data;
  logic [31:0] exp_inst, exp_drdata;

  mem_arbiter #(.TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_stb_inst(i_stb_inst), .i_iaddr(i_iaddr), .i_flush_inst(i_flush_inst),
    .o_ack_inst(o_ack_inst), .o_inst(o_inst),
    .i_stb_data(i_stb_data), .i_daddr(i_daddr), .i_dwdata(i_dwdata),
    .i_dwe(i_dwe), .i_dsel(i_dsel),
    .o_ack_data(o_ack_data), .o_drdata(o_drdata), .o_err(o_err),
    .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_sel(o_mem_sel),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_stb"},   32'(o_mem_stb), 32'd0);
    check({tag, "_acki"},  32'(o_ack_inst), 32'd0);
    check({tag, "_ackd"},  32'(o_ack_data), 32'd0);
    check({tag, "_err"},   32'(o_err), 32'd0);
    check({tag, "_inst"},  o_inst, 32'd0);
    check({tag, "_drd"},   o_drdata, 32'd0);
    check({tag, "_addr"},  o_mem_addr, 32'd0);
    check({tag, "_we"},    32'(o_mem_we), 32'd0);
    check({tag, "_wdata"}, o_mem_wdata, 32'd0);
    check({tag, "_sel"},   32'(o_mem_sel), 32'd0);
  endtask

  // Memory model: acks after mem_wait strobe cycles; random stray acks and
  // junk read data whenever no transfer is on the bus.
  initial begin
    int cnt;
    cnt = 0;
    i_mem_ack = 1'b0;
    i_mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n || !o_mem_stb) begin
        cnt = 0;
        i_mem_ack = 1'($urandom_range(0, 1));
        i_mem_rdata = $urandom;
      end else begin
        i_mem_ack = (cnt == mem_wait);
        i_mem_rdata = i_mem_ack ? mem_fn(o_mem_addr) : $urandom;
        cnt++;
      end
    end
  end

  // Bus-wide invariants sampled every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ack_exclusive", 32'(o_ack_inst & o_ack_data), 32'd0);
        check("err_needs_ack", 32'(o_err & ~(o_ack_inst | o_ack_data)), 32'd0);
      end
    end
  end

  // One request on one port, entered and left at an IDLE-cycle negedge.
  task automatic single(input bit is_inst, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit we, input logic [3:0] sel, input int w, input bit withdraw);
    int n_exp, stb_cnt, s, ack_s;
    bit err_exp;
    logic [31:0] e_wdata;
    logic [3:0]  e_sel;
    bit e_we;
    mem_wait = w;
    err_exp = (w >= T);
    n_exp = err_exp ? T : w + 1;
    e_we = is_inst ? 1'b0 : we;
    e_wdata = is_inst ? 32'd0 : wdata;
    e_sel = is_inst ? 4'hF : sel;
    stb_cnt = 0; s = 0; ack_s = 0;
    if (is_inst) begin
      i_iaddr = addr; i_stb_inst = 1'b1;
    end else begin
      i_daddr = addr; i_dwdata = wdata; i_dwe = we; i_dsel = sel; i_stb_data = 1'b1;
    end
    while (ack_s == 0 && s < 40) begin
      @(negedge clk);
      s++;
      if (o_mem_stb) begin
        stb_cnt++;
        check("bus_addr", o_mem_addr, addr);
        check("bus_we", 32'(o_mem_we), 32'(e_we));
        check("bus_wdata", o_mem_wdata, e_wdata);
        check("bus_sel", 32'(o_mem_sel), 32'(e_sel));
        if (withdraw) begin
          i_stb_inst = 1'b0; i_stb_data = 1'b0;
          i_iaddr = $urandom; i_daddr = $urandom; i_dwdata = $urandom;
          i_dsel = 4'($urandom); i_dwe = 1'($urandom);
        end
      end
      if (o_ack_inst || o_ack_data) begin
        ack_s = s;
        check("ack_port", 32'(o_ack_inst), 32'(is_inst));
      end
    end
    i_stb_inst = 1'b0;
    i_stb_data = 1'b0;
    if (is_inst) exp_inst = err_exp ? NOP : mem_fn(addr);
    else if (!we) exp_drdata = err_exp ? 32'd0 : mem_fn(addr);
    last_data = !is_inst;
    check("ack_latency", 32'(ack_s), 32'(n_exp + 1));
    check("stb_cycles", 32'(stb_cnt), 32'(n_exp));
    check("err_flag", 32'(o_err), 32'(err_exp));
    check("inst_value", o_inst, exp_inst);
    check("drdata_value", o_drdata, exp_drdata);
    @(negedge clk);
  endtask

  // Fetch and data requested in the same cycle; checks grant order.
  task automatic pair(input int w);
    logic [31:0] ia, da;
    bit data_first, dwe;
    int n, s, si, sd;
    ia = {1'b0, 31'($urandom)};
    da = {1'b1, 31'($urandom)};
    dwe = 1'($urandom);
    data_first = !last_data;
    n = w + 1;
    mem_wait = w;
    i_iaddr = ia; i_stb_inst = 1'b1;
    i_daddr = da; i_dwdata = $urandom; i_dwe = dwe; i_dsel = 4'($urandom); i_stb_data = 1'b1;
    s = 0; si = 0; sd = 0;
    while ((si == 0 || sd == 0) && s < 60) begin
      @(negedge clk);
      s++;
      if (o_ack_inst) begin
        si = s; i_stb_inst = 1'b0;
        exp_inst = mem_fn(ia);
        check("pair_inst", o_inst, exp_inst);
      end
      if (o_ack_data) begin
        sd = s; i_stb_data = 1'b0;
        if (!dwe) exp_drdata = mem_fn(da);
        check("pair_drdata", o_drdata, exp_drdata);
      end
    end
    i_stb_inst = 1'b0;
    i_stb_data = 1'b0;
    check("pair_inst_ack_at", 32'(si), 32'(data_first ? 2 * n + 3 : n + 1));
    check("pair_data_ack_at", 32'(sd), 32'(data_first ? n + 1 : 2 * n + 3));
    last_data = !data_first;
    @(negedge clk);
  endtask

  initial begin
    int kind;
    bit saw_acki;
    int s, sd;
    rst_n = 1'b0;
    i_stb_inst = 0; i_flush_inst = 0; i_stb_data = 0; i_dwe = 0;
    i_iaddr = 0; i_daddr = 0; i_dwdata = 0; i_dsel = 0;
    last_data = 1'b0; exp_inst = 0; exp_drdata = 0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Tie from reset: data first, then alternation puts fetch first
    pair(0);
    pair(1);
    // Fetch of 0x100 returning 0x00500093
    single(1'b1, 32'h0000_0100, 32'd0, 1'b0, 4'd0, 1, 1'b0);
    // Store: o_drdata must stay unchanged
    single(1'b0, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 4'b0011, 2, 1'b0);
    // Watchdog: fetch and load never acked; last-chance ack
    single(1'b1, $urandom, 32'd0, 1'b0, 4'd0, 50, 1'b0);
    single(1'b0, $urandom, $urandom, 1'b0, 4'hF, T, 1'b0);
    single(1'b0, $urandom, $urandom, 1'b0, 4'h5, T - 1, 1'b0);

    // Flush in IDLE masks the fetch for that cycle
    i_stb_inst = 1'b1; i_iaddr = 32'h0000_4000; i_flush_inst = 1'b1;
    @(negedge clk);
    check("idle_flush_mask", 32'(o_mem_stb), 32'd0);
    i_flush_inst = 1'b0;
    single(1'b1, 32'h0000_4000, 32'd0, 1'b0, 4'd0, 0, 1'b0);

    // Flush during BUSY_I with a data request waiting
    mem_wait = 2;
    i_iaddr = $urandom; i_stb_inst = 1'b1;
    s = 0; sd = 0; saw_acki = 0;
    while (sd == 0 && s < 30) begin
      @(negedge clk);
      s++;
      if (s == 1) begin
        i_stb_inst = 1'b0; i_flush_inst = 1'b1;
        i_daddr = $urandom; i_dwe = 1'b0; i_dsel = 4'hF; i_stb_data = 1'b1;
      end else begin
        i_flush_inst = 1'b0;
      end
      if (o_ack_inst) saw_acki = 1;
      if (o_ack_data) begin
        sd = s;
        exp_drdata = mem_fn(i_daddr);
        check("flush_drdata", o_drdata, exp_drdata);
      end
    end
    i_stb_data = 1'b0;
    last_data = 1'b1;
    check("flush_no_ack", 32'(saw_acki), 32'd0);
    check("flush_inst_kept", o_inst, exp_inst);
    check("flush_data_ack_at", 32'(sd), 32'd9);
    @(negedge clk);

    // Reset pulse during BUSY_D
    mem_wait = 50;
    i_daddr = $urandom; i_dwe = 1'b0; i_dsel = 4'hF; i_stb_data = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_d_stb", 32'(o_mem_stb), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_stb", 32'(o_mem_stb), 32'd0);
    i_stb_data = 1'b0;
    @(negedge clk);
    check_zero_outputs("rst_mid");
    rst_n = 1'b1;
    last_data = 1'b0; exp_inst = 0; exp_drdata = 0;
    single(1'b0, $urandom, $urandom, 1'b0, 4'hF, 0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0)
        pair($urandom_range(0, 2));
      else
        single(1'($urandom), $urandom, $urandom, 1'($urandom), 4'($urandom),
               $urandom_range(0, T + 1), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
